// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle main control unit.
// Contents: FSM state encoding, instruction classes, opcode values, ALU control codes
// (as consumed by alu_control.ALUControl) and alu_src_b mux selections.
// Shared with alu_control and the datapath.

package ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StExecR,
        StExecI,
        StMemAddr,
        StMemRd,
        StMemWr,
        StWbReg,
        StWbMem,
        StBranch,
        StJump,
        StHalt
    } state_t;

    typedef enum logic [2:0] {
        ClsR,
        ClsAddi,
        ClsLw,
        ClsSw,
        ClsBeq,
        ClsJmp,
        ClsHalt,
        ClsIllegal
    } instr_class_t;

    // Opcodes; 9..E are undefined.
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SW   = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    // ALU control codes.
    localparam logic [2:0] ALU_NONE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;

    // alu_op: only the default code is used; the rest are reserved.
    localparam logic [1:0] ALU_OP_DEFAULT = 2'b00;

    // alu_src_b mux selections.
    localparam logic [1:0] SRCB_REG = 2'b00;  // register operand B
    localparam logic [1:0] SRCB_ONE = 2'b01;  // constant 1 (PC increment)
    localparam logic [1:0] SRCB_IMM = 2'b10;  // immediate

endpackage

// File: rtl/main_control_if.sv
// main_control_if: datapath/memory control bundle between main_control and the datapath.
// Parameters: OPW opcode width, CNTW performance counter width.
// master modport (controller): inputs run, opcode, zero, mem_ready;
//   outputs ALU codes, memory strobes, register enables, mux selects, status and counters.
// slave modport (datapath side): the mirror image.

interface main_control_if #(
    parameter int unsigned OPW  = 4,
    parameter int unsigned CNTW = 32
);
    logic            run;
    logic [OPW-1:0]  opcode;
    logic            zero;
    logic            mem_ready;

    logic [1:0]      alu_op;
    logic [2:0]      alu_ctrl;
    logic            mem_read;
    logic            mem_write;
    logic            iord;
    logic            ir_write;
    logic            pc_write;
    logic            reg_write;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic            mem_to_reg;
    logic            reg_dst;
    logic            pc_src;
    logic            halted;
    logic            illegal_op;
    logic [CNTW-1:0] cycle_count;
    logic [CNTW-1:0] instr_count;

    modport master (
        input  run, opcode, zero, mem_ready,
        output alu_op, alu_ctrl, mem_read, mem_write, iord, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, mem_to_reg, reg_dst, pc_src, halted, illegal_op,
               cycle_count, instr_count
    );

    modport slave (
        output run, opcode, zero, mem_ready,
        input  alu_op, alu_ctrl, mem_read, mem_write, iord, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, mem_to_reg, reg_dst, pc_src, halted, illegal_op,
               cycle_count, instr_count
    );

endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode decoder.
// Ports: i_opcode  - opcode from the instruction register
//        o_class   - instruction class steering the main FSM
//        o_alu_ctrl- ALU operation for R-type execution (ADD otherwise)
//        o_illegal - opcode is undefined

module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int unsigned OPW = 4
) (
    input  logic [OPW-1:0] i_opcode,
    output instr_class_t   o_class,
    output logic [2:0]     o_alu_ctrl,
    output logic           o_illegal
);

    always_comb begin
        o_class    = ClsIllegal;
        o_alu_ctrl = ALU_ADD;
        case (i_opcode)
            OP_ADD:  begin o_class = ClsR; o_alu_ctrl = ALU_ADD; end
            OP_SUB:  begin o_class = ClsR; o_alu_ctrl = ALU_SUB; end
            OP_AND:  begin o_class = ClsR; o_alu_ctrl = ALU_AND; end
            OP_OR:   begin o_class = ClsR; o_alu_ctrl = ALU_OR;  end
            OP_ADDI: o_class = ClsAddi;
            OP_LW:   o_class = ClsLw;
            OP_SW:   o_class = ClsSw;
            OP_BEQ:  o_class = ClsBeq;
            OP_JMP:  o_class = ClsJmp;
            OP_HALT: o_class = ClsHalt;
            default: o_class = ClsIllegal;
        endcase
    end

    assign o_illegal = (o_class == ClsIllegal);

endmodule

// File: rtl/main_control.sv
// main_control: multi-cycle main control unit for the CPU datapath.
// Ports: clk    - rising-edge clock
//        reset  - asynchronous active-high reset; forces every output to 0 while high
//        io_bus - main_control_if.master: run/opcode/zero/mem_ready in, datapath strobes,
//                 ALU codes, halted, illegal_op and performance counters out
// Build option: define MAIN_CTRL_PERF_EN to implement cycle_count/instr_count;
// otherwise both are tied to 0 and no counter flops exist.

module main_control
    import ctrl_pkg::*;
#(
    parameter int unsigned OPW  = 4,
    parameter int unsigned CNTW = 32
) (
    input  logic          clk,
    input  logic          reset,
    main_control_if.master io_bus
);

    state_t       r_state;
    instr_class_t w_class;
    logic [2:0]   w_alu_ctrl;
    logic         w_illegal;

    ctrl_decode #(
        .OPW (OPW)
    ) u_decode (
        .i_opcode   (io_bus.opcode),
        .o_class    (w_class),
        .o_alu_ctrl (w_alu_ctrl),
        .o_illegal  (w_illegal)
    );

    // Next-state sequencing. The opcode is held in the IR from DECODE onward, so later
    // states re-use the live decode rather than a registered copy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StFetch;
        end else begin
            unique case (r_state)
                StFetch:   if (io_bus.run && io_bus.mem_ready) r_state <= StDecode;
                StDecode: begin
                    case (w_class)
                        ClsR:         r_state <= StExecR;
                        ClsAddi:      r_state <= StExecI;
                        ClsLw, ClsSw: r_state <= StMemAddr;
                        ClsBeq:       r_state <= StBranch;
                        ClsJmp:       r_state <= StJump;
                        ClsHalt:      r_state <= StHalt;
                        default:      r_state <= StFetch;
                    endcase
                end
                StExecR:   r_state <= StWbReg;
                StExecI:   r_state <= StWbReg;
                StMemAddr: r_state <= (w_class == ClsLw) ? StMemRd : StMemWr;
                StMemRd:   if (io_bus.mem_ready) r_state <= StWbMem;
                StMemWr:   if (io_bus.mem_ready) r_state <= StFetch;
                StWbReg:   r_state <= StFetch;
                StWbMem:   r_state <= StFetch;
                StBranch:  r_state <= StFetch;
                StJump:    r_state <= StFetch;
                StHalt:    r_state <= StHalt;
                default:   r_state <= StFetch;
            endcase
        end
    end

    // Output decode. Moore on r_state except the FETCH completion (run && mem_ready) and
    // the BRANCH pc_write (zero). Gated by reset so outputs are 0 while reset is held.
    always_comb begin
        io_bus.alu_op     = ALU_OP_DEFAULT;
        io_bus.alu_ctrl   = ALU_NONE;
        io_bus.mem_read   = 1'b0;
        io_bus.mem_write  = 1'b0;
        io_bus.iord       = 1'b0;
        io_bus.ir_write   = 1'b0;
        io_bus.pc_write   = 1'b0;
        io_bus.reg_write  = 1'b0;
        io_bus.alu_src_a  = 1'b0;
        io_bus.alu_src_b  = SRCB_REG;
        io_bus.mem_to_reg = 1'b0;
        io_bus.reg_dst    = 1'b0;
        io_bus.pc_src     = 1'b0;
        io_bus.halted     = 1'b0;
        io_bus.illegal_op = 1'b0;
        if (!reset) begin
            unique case (r_state)
                StFetch: begin
                    io_bus.mem_read  = io_bus.run;
                    io_bus.alu_ctrl  = ALU_ADD;
                    io_bus.alu_src_b = SRCB_ONE;
                    io_bus.ir_write  = io_bus.run && io_bus.mem_ready;
                    io_bus.pc_write  = io_bus.run && io_bus.mem_ready;
                end
                StDecode: begin
                    io_bus.alu_ctrl   = ALU_ADD;
                    io_bus.illegal_op = w_illegal;
                end
                StExecR: begin
                    io_bus.alu_ctrl  = w_alu_ctrl;
                    io_bus.alu_src_a = 1'b1;
                    io_bus.alu_src_b = SRCB_REG;
                end
                StExecI, StMemAddr: begin
                    io_bus.alu_ctrl  = ALU_ADD;
                    io_bus.alu_src_b = SRCB_IMM;
                end
                StMemRd: begin
                    io_bus.mem_read = 1'b1;
                    io_bus.iord     = 1'b1;
                end
                StMemWr: begin
                    io_bus.mem_write = 1'b1;
                    io_bus.iord      = 1'b1;
                end
                StWbReg: begin
                    io_bus.reg_write = 1'b1;
                    io_bus.reg_dst   = (w_class == ClsR);
                end
                StWbMem: begin
                    io_bus.reg_write  = 1'b1;
                    io_bus.mem_to_reg = 1'b1;
                end
                StBranch: begin
                    io_bus.alu_ctrl = ALU_SUB;
                    io_bus.pc_src   = 1'b1;
                    io_bus.pc_write = io_bus.zero;
                end
                StJump: begin
                    io_bus.pc_write = 1'b1;
                    io_bus.pc_src   = 1'b1;
                end
                StHalt: io_bus.halted = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MAIN_CTRL_PERF_EN
    logic [CNTW-1:0] r_cycle_count;
    logic [CNTW-1:0] r_instr_count;
    logic            w_instr_done;

    // An instruction retires on any transition into FETCH except the illegal-opcode bail-out.
    assign w_instr_done = (r_state == StWbReg) || (r_state == StWbMem) ||
                          (r_state == StBranch) || (r_state == StJump) ||
                          ((r_state == StMemWr) && io_bus.mem_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle_count <= '0;
            r_instr_count <= '0;
        end else begin
            if (r_state != StHalt) r_cycle_count <= r_cycle_count + CNTW'(1);
            if (w_instr_done)      r_instr_count <= r_instr_count + CNTW'(1);
        end
    end

    assign io_bus.cycle_count = r_cycle_count;
    assign io_bus.instr_count = r_instr_count;
`else
    assign io_bus.cycle_count = {CNTW{1'b0}};
    assign io_bus.instr_count = {CNTW{1'b0}};
`endif

endmodule

// File: tb/tb_main_control.sv
// tb_main_control: directed self-checking bench for main_control.
// Inputs change on the falling edge; outputs are sampled 1ns later, well before the next
// rising edge. Expected strobe sets are hand-written per state.

module tb_main_control;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       pc_src;
        logic       halted;
        logic       illegal_op;
        logic [2:0] alu_ctrl;
        logic [1:0] alu_op;
    } sig_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    main_control_if #(.OPW(4), .CNTW(32)) bus ();

    main_control #(
        .OPW  (4),
        .CNTW (32)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus.master)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_cyc   = '0;
    logic [31:0] exp_instr = '0;
    logic [31:0] frozen;

    sig_t S_ZERO, FETCH_GO, FETCH_WAIT, FETCH_IDLE, DECODE, DEC_ILL;
    sig_t EXR_ADD, EXR_SUB, EXR_OR, EXI, WBR_R, WBR_I, MADDR, MRD, MWR, WBM;
    sig_t BR_T, BR_N, JMP_S, HALT_S;

    function automatic sig_t mk(input logic mr, mw, io, irw, pcw, rw, sa,
                                input logic [1:0] sb,
                                input logic m2r, rd, ps, h, il,
                                input logic [2:0] ac);
        sig_t s;
        s = '{mem_read: mr, mem_write: mw, iord: io, ir_write: irw, pc_write: pcw,
              reg_write: rw, alu_src_a: sa, alu_src_b: sb, mem_to_reg: m2r, reg_dst: rd,
              pc_src: ps, halted: h, illegal_op: il, alu_ctrl: ac, alu_op: 2'b00};
        return s;
    endfunction

    function automatic sig_t observe();
        sig_t s;
        s = '{mem_read: bus.mem_read, mem_write: bus.mem_write, iord: bus.iord,
              ir_write: bus.ir_write, pc_write: bus.pc_write, reg_write: bus.reg_write,
              alu_src_a: bus.alu_src_a, alu_src_b: bus.alu_src_b,
              mem_to_reg: bus.mem_to_reg, reg_dst: bus.reg_dst, pc_src: bus.pc_src,
              halted: bus.halted, illegal_op: bus.illegal_op, alu_ctrl: bus.alu_ctrl,
              alu_op: bus.alu_op};
        return s;
    endfunction

    // Check the strobes for the current cycle, then advance one clock.
    task automatic step(input string tag, input sig_t exp, input bit done);
        sig_t o;
        #1;
        o = observe();
        n_cmp++;
        assert (o === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, exp);
        end
        @(posedge clk);
        if (!exp.halted) exp_cyc++;
        if (done) exp_instr++;
        @(negedge clk);
    endtask

    task automatic chk_cnt(input string tag);
        logic [31:0] ec, ei;
`ifdef MAIN_CTRL_PERF_EN
        ec = exp_cyc;
        ei = exp_instr;
`else
        ec = '0;
        ei = '0;
`endif
        n_cmp++;
        assert (bus.cycle_count === ec) else begin
            n_fail++;
            $error("FAIL %s.cycle_count: observed %0d expected %0d", tag, bus.cycle_count, ec);
        end
        n_cmp++;
        assert (bus.instr_count === ei) else begin
            n_fail++;
            $error("FAIL %s.instr_count: observed %0d expected %0d", tag, bus.instr_count, ei);
        end
    endtask

    task automatic chk_zero(input string tag);
        sig_t o;
        o = observe();
        n_cmp++;
        assert (o === S_ZERO) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, S_ZERO);
        end
    endtask

    initial begin
        //            mr mw io ir pw rw sa sb     m2r rd ps h  il alu
        S_ZERO     = '0;
        FETCH_GO   = mk(1, 0, 0, 1, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0, 3'b001);
        FETCH_WAIT = mk(1, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 3'b001);
        FETCH_IDLE = mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 3'b001);
        DECODE     = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3'b001);
        DEC_ILL    = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 3'b001);
        EXR_ADD    = mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 3'b001);
        EXR_SUB    = mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 3'b010);
        EXR_OR     = mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 3'b100);
        EXI        = mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 3'b001);
        WBR_R      = mk(0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 1, 0, 0, 0, 3'b000);
        WBR_I      = mk(0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 3'b000);
        MADDR      = mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 3'b001);
        MRD        = mk(1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3'b000);
        MWR        = mk(0, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3'b000);
        WBM        = mk(0, 0, 0, 0, 0, 1, 0, 2'b00, 1, 0, 0, 0, 0, 3'b000);
        BR_T       = mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 1, 0, 0, 3'b010);
        BR_N       = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 3'b010);
        JMP_S      = mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 1, 0, 0, 3'b000);
        HALT_S     = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 3'b000);

        // Reset with FETCH-active inputs: every output must still read 0.
        reset = 1'b1; bus.run = 1'b1; bus.mem_ready = 1'b1; bus.zero = 1'b0;
        bus.opcode = 4'h0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_zero("reset_outputs");
        chk_cnt("reset");
        @(negedge clk);
        reset = 1'b0;

        // ADD: 4 cycles, back in FETCH on cycle 5.
        bus.opcode = 4'h0;
        step("add.fetch", FETCH_GO, 0);
        step("add.decode", DECODE, 0);
        step("add.exec", EXR_ADD, 0);
        step("add.wb", WBR_R, 1);
        chk_cnt("after_add");

        // SUB with one fetch wait state.
        bus.opcode = 4'h1; bus.mem_ready = 1'b0;
        step("sub.fetch_wait", FETCH_WAIT, 0);
        bus.mem_ready = 1'b1;
        step("sub.fetch", FETCH_GO, 0);
        step("sub.decode", DECODE, 0);
        step("sub.exec", EXR_SUB, 0);
        step("sub.wb", WBR_R, 1);

        // OR.
        bus.opcode = 4'h3;
        step("or.fetch", FETCH_GO, 0);
        step("or.decode", DECODE, 0);
        step("or.exec", EXR_OR, 0);
        step("or.wb", WBR_R, 1);

        // ADDI: reg_dst=0.
        bus.opcode = 4'h4;
        step("addi.fetch", FETCH_GO, 0);
        step("addi.decode", DECODE, 0);
        step("addi.exec", EXI, 0);
        step("addi.wb", WBR_I, 1);
        chk_cnt("after_addi");

        // LW with 2 wait states in MEM_RD: 7 cycles.
        bus.opcode = 4'h5;
        step("lw.fetch", FETCH_GO, 0);
        step("lw.decode", DECODE, 0);
        step("lw.addr", MADDR, 0);
        bus.mem_ready = 1'b0;
        step("lw.rd_wait1", MRD, 0);
        step("lw.rd_wait2", MRD, 0);
        bus.mem_ready = 1'b1;
        step("lw.rd_done", MRD, 0);
        step("lw.wb", WBM, 1);
        chk_cnt("after_lw");

        // SW, no wait states: 4 cycles.
        bus.opcode = 4'h6;
        step("sw.fetch", FETCH_GO, 0);
        step("sw.decode", DECODE, 0);
        step("sw.addr", MADDR, 0);
        step("sw.wr", MWR, 1);

        // BEQ taken and not taken: 3 cycles each.
        bus.opcode = 4'h7; bus.zero = 1'b1;
        step("beq_t.fetch", FETCH_GO, 0);
        step("beq_t.decode", DECODE, 0);
        step("beq_t.branch", BR_T, 1);
        bus.zero = 1'b0;
        step("beq_n.fetch", FETCH_GO, 0);
        step("beq_n.decode", DECODE, 0);
        step("beq_n.branch", BR_N, 1);

        // JMP.
        bus.opcode = 4'h8;
        step("jmp.fetch", FETCH_GO, 0);
        step("jmp.decode", DECODE, 0);
        step("jmp.jump", JMP_S, 1);
        chk_cnt("after_jmp");

        // Illegal opcode: one-cycle pulse, back to FETCH, not retired.
        bus.opcode = 4'hA;
        step("ill.fetch", FETCH_GO, 0);
        step("ill.decode", DEC_ILL, 0);
        bus.run = 1'b0;
        step("ill.back_fetch", FETCH_IDLE, 0);
        chk_cnt("after_illegal");

        // run drops mid-instruction: ADD completes, then the unit idles in FETCH.
        bus.run = 1'b1; bus.opcode = 4'h0;
        step("rundrop.fetch", FETCH_GO, 0);
        bus.run = 1'b0;
        step("rundrop.decode", DECODE, 0);
        step("rundrop.exec", EXR_ADD, 0);
        step("rundrop.wb", WBR_R, 1);
        step("rundrop.idle1", FETCH_IDLE, 0);
        step("rundrop.idle2", FETCH_IDLE, 0);
        chk_cnt("after_rundrop");

        // Reset during a MEM_WR wait abandons the write.
        bus.run = 1'b1; bus.opcode = 4'h6;
        step("swr.fetch", FETCH_GO, 0);
        step("swr.decode", DECODE, 0);
        step("swr.addr", MADDR, 0);
        bus.mem_ready = 1'b0;
        step("swr.wr_wait", MWR, 0);
        reset = 1'b1;
        #1;
        chk_zero("swr.reset_outputs");
        exp_cyc = '0; exp_instr = '0;
        chk_cnt("swr.reset");
        @(negedge clk);
        reset = 1'b0;
        step("swr.after_reset", FETCH_WAIT, 0);
        bus.mem_ready = 1'b1;

        // HALT: frozen for 100 cycles regardless of inputs.
        bus.opcode = 4'hF;
        step("halt.fetch", FETCH_GO, 0);
        step("halt.decode", DECODE, 0);
        frozen = exp_cyc;
        for (int i = 0; i < 100; i++) begin
            bus.mem_ready = i[0];
            bus.zero = i[1];
            step("halt.hold", HALT_S, 0);
        end
        chk_cnt("halt_frozen");
        n_cmp++;
        assert (exp_cyc === frozen) else begin
            n_fail++;
            $error("FAIL halt.model_freeze: observed %0d expected %0d", exp_cyc, frozen);
        end

        // Reset out of HALT.
        reset = 1'b1;
        #1;
        chk_zero("halt.reset_outputs");
        exp_cyc = '0; exp_instr = '0;
        chk_cnt("halt.reset");
        @(negedge clk);
        reset = 1'b0; bus.mem_ready = 1'b1; bus.opcode = 4'h0;
        step("post_halt.fetch", FETCH_GO, 0);
        chk_cnt("post_halt");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/main_control.md
# main_control

Multi-cycle main control unit for the CPU datapath; sits directly upstream of `alu_control`. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the datapath strobes and supplies `alu_op`/`alu_ctrl`, which feed `alu_control`'s `instruction`/`ALUControl` inputs. Memory accesses use a ready handshake, so instruction latency stretches with memory wait states.

## Interface
- `OPW`, 4: opcode width
- `CNTW`, 32: performance counter width
- `clk` in 1: sole clock, rising edge
- `reset` in 1: asynchronous, active-high
- `run` in 1: permits a new fetch
- `opcode` in OPW: opcode from the instruction register; valid from DECODE onward
- `zero` in 1: ALU zero flag
- `mem_ready` in 1: memory completes the current read or write this cycle
- `alu_op` out 2: to `alu_control.instruction`; always 2'b00 (other codes reserved)
- `alu_ctrl` out 3: to `alu_control.ALUControl`; 001 ADD, 010 SUB, 011 AND, 100 OR
- `mem_read`, `mem_write` out 1 each: memory strobes, held until `mem_ready`
- `iord` out 1: address mux; 0 = PC, 1 = ALU result
- `ir_write`, `pc_write`, `reg_write` out 1 each: register enables
- `alu_src_a` out 1; `alu_src_b` out 2: ALU operand muxes
- `mem_to_reg`, `reg_dst`, `pc_src` out 1 each: writeback and PC muxes
- `halted` out 1: in HALT
- `illegal_op` out 1: one-cycle pulse on an undefined opcode
- `cycle_count`, `instr_count` out CNTW each: performance counters

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI, 5 LW, 6 SW, 7 BEQ, 8 JMP, F HALT; 9–E are illegal.
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_REG, WB_MEM, BRANCH, JUMP, HALT.
- FETCH:
  - Drives `mem_read`=`run`, `iord`=0, `alu_ctrl`=ADD, `alu_src_b`=01 (PC+1).
  - When `run && mem_ready`: assert `ir_write` and `pc_write`, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: `alu_ctrl`=ADD (branch target). Next state by opcode:
  - R-type (0–3) → EXEC_R; ADDI → EXEC_I; LW/SW → MEM_ADDR.
  - BEQ → BRANCH; JMP → JUMP; HALT → HALT.
  - Illegal → FETCH, pulsing `illegal_op`.
- EXEC_R: `alu_ctrl` per opcode, `alu_src_a`=1, `alu_src_b`=00 → WB_REG.
- EXEC_I: ADD, `alu_src_b`=10 → WB_REG.
- WB_REG: `reg_write`=1; `reg_dst`=1 for R-type, 0 for ADDI → FETCH.
- MEM_ADDR: ADD, `alu_src_b`=10 → MEM_RD for LW, MEM_WR for SW.
- MEM_RD / MEM_WR:
  - `iord`=1, strobe held high; stay until `mem_ready`.
  - MEM_RD → WB_MEM; MEM_WR → FETCH.
- WB_MEM: `reg_write`=1, `mem_to_reg`=1 → FETCH.
- BRANCH: SUB, `pc_src`=1, `pc_write`=`zero` (the only Mealy path on `zero`) → FETCH.
- JUMP: `pc_write`=1, `pc_src`=1 → FETCH.
- HALT: `halted`=1, no strobes. Exit only by reset.
- All strobes not listed for a state are 0.

## Timing
- Reset: state=FETCH. While `reset` is high, every output is 0, including the counters.
- Outputs decode from the state register, except FETCH/MEM_* completion (`mem_ready`) and BRANCH (`zero`).
- Cycles per instruction with zero wait states:
  - R-type, ADDI, SW: 4
  - LW: 5
  - BEQ, JMP: 3
- Each cycle `mem_ready` is low adds one cycle.
- `run` dropping mid-instruction does not abort; the instruction completes, then the unit idles in FETCH.
- `mem_ready` high outside a memory state is ignored.
- Reset asserted mid-access returns to FETCH immediately; the pending access is abandoned.

## Configuration
- `MAIN_CTRL_PERF_EN` defined:
  - `cycle_count` increments every cycle out of reset except in HALT.
  - `instr_count` increments on entry to FETCH from any completing state. Illegal opcodes do not count.
  - Both counters wrap at 2^CNTW.
- Undefined: both ports are tied to 0 and no counter flops exist.

## Structure
- `ctrl_pkg`: `state_t` enum, opcode localparams, ALU control encodings (`ALU_ADD`=3'b001 etc.), `alu_src_b` mux codes. Shared with `alu_control` and the datapath.
- Sub-module `ctrl_decode`: combinational. Maps opcode to instruction class and `alu_ctrl`, and flags illegal opcodes.

## Test plan
- Reset, `run`=1, ADD, `mem_ready`=1 → FETCH, DECODE, EXEC_R (`alu_ctrl`=001), WB_REG (`reg_write`, `reg_dst`=1); back in FETCH on cycle 5.
- LW with `mem_ready` low for 2 cycles in MEM_RD → `mem_read`+`iord` held 3 cycles; WB_MEM `mem_to_reg`=1; total 7 cycles.
- BEQ with `zero`=1 → `pc_write`=1 in BRANCH. Repeat with `zero`=0 → `pc_write`=0; both take 3 cycles.
- Opcode 4'hA → one-cycle `illegal_op` pulse, returns to FETCH, `instr_count` unchanged.
- HALT → `halted`=1, all strobes 0 for 100 cycles, `cycle_count` frozen. Reset → FETCH, counters 0.
- Reset asserted during MEM_WR wait → all outputs 0 that cycle; after release, state FETCH, `mem_write`=0.
